// File: rtl/sram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bist_ctrl
//  Brief    : March BIST initiator for a synchronous read-first SRAM port;
//             records pass/fail plus the first failing address and data.
//  Revision : 1.0
// ============================================================================
module sram_bist_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [DATA_WIDTH-1:0] c_pat   = PATTERN;
  localparam logic [DATA_WIDTH-1:0] c_npat  = ~PATTERN;
  localparam logic [ADDR_WIDTH-1:0] c_first = '0;
  localparam logic [ADDR_WIDTH-1:0] c_last  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_M0    = 3'd1,
    S_M1    = 3'd2,
    S_M2    = 3'd3,
    S_M3    = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                  r_state;
  logic                    r_drain;
  // Stage 1 travels with the issued SRAM operation (its address is sram_addr);
  // stage 2 lines up with the sram_dout produced by that operation.
  logic                    r_s1_valid;
  logic [DATA_WIDTH-1:0]   r_s1_exp;
  logic                    r_s2_valid;
  logic [DATA_WIDTH-1:0]   r_s2_exp;
  logic [ADDR_WIDTH-1:0]   r_s2_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_drain    <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_exp   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_exp   <= r_s1_exp;
      r_s2_addr  <= sram_addr;

      if (r_s2_valid && (sram_dout != r_s2_exp)) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= r_s2_addr;
          fail_data <= sram_dout;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          r_s1_valid <= 1'b0;
          if (start) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            r_state    <= S_M0;
            sram_we    <= 1'b1;
            sram_addr  <= c_first;
            sram_din   <= c_pat;
          end
        end

        S_M0: begin
          sram_we <= 1'b1;
          if (sram_addr == c_last) begin
            r_state    <= S_M1;
            sram_addr  <= c_first;
            sram_din   <= c_npat;
            r_s1_valid <= 1'b1;
            r_s1_exp   <= c_pat;
          end else begin
            sram_addr  <= sram_addr + 1'b1;
            sram_din   <= c_pat;
            r_s1_valid <= 1'b0;
          end
        end

        S_M1: begin
          sram_we    <= 1'b1;
          r_s1_valid <= 1'b1;
          // M2 begins at the top address, so the counter holds for one step.
          if (sram_addr == c_last) begin
            r_state  <= S_M2;
            sram_din <= c_pat;
            r_s1_exp <= c_npat;
          end else begin
            sram_addr <= sram_addr + 1'b1;
            sram_din  <= c_npat;
            r_s1_exp  <= c_pat;
          end
        end

        S_M2: begin
          r_s1_valid <= 1'b1;
          sram_din   <= c_pat;
          if (sram_addr == c_first) begin
            r_state   <= S_M3;
            sram_we   <= 1'b0;
            sram_addr <= c_last;
            r_s1_exp  <= c_pat;
          end else begin
            sram_we   <= 1'b1;
            sram_addr <= sram_addr - 1'b1;
            r_s1_exp  <= c_npat;
          end
        end

        S_M3: begin
          sram_we  <= 1'b0;
          sram_din <= c_pat;
          if (sram_addr == c_first) begin
            r_state    <= S_DRAIN;
            r_drain    <= 1'b0;
            r_s1_valid <= 1'b0;
          end else begin
            sram_addr  <= sram_addr - 1'b1;
            r_s1_valid <= 1'b1;
            r_s1_exp   <= c_pat;
          end
        end

        S_DRAIN: begin
          sram_we    <= 1'b0;
          r_s1_valid <= 1'b0;
          if (r_drain) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_s1_valid <= 1'b0;
          sram_we    <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_bist_ctrl
//  Brief    : Self-checking bench with a faultable SRAM model and a March
//             reference computed over an abstract memory array.
//  Revision : 1.0
// ============================================================================
module tb_sram_bist_ctrl;

  localparam int N = 16;
  localparam logic [7:0] P = 8'h55;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, fail, sram_we;
  logic [3:0] fail_addr, sram_addr;
  logic [7:0] fail_data, sram_din, sram_dout;

  int checks = 0;
  int errors = 0;

  // Fault configuration shared by the SRAM model and the reference.
  logic [7:0] mem [N];
  logic [7:0] sa0 [N];
  logic [7:0] sa1 [N];
  bit         wf;
  logic [7:0] rv;

  always #5 clk = ~clk;

  sram_bist_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PATTERN(8'h55)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_data(fail_data),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  always @(posedge clk) begin
    rv = (wf && sram_we) ? sram_din : mem[sram_addr];
    sram_dout <= (rv & ~sa0[sram_addr]) | sa1[sram_addr];
    if (sram_we) mem[sram_addr] <= sram_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_addr(input int k);
    int el = k / N;
    int i  = k % N;
    return (el < 2) ? i : (N - 1 - i);
  endfunction

  function automatic logic [7:0] ref_din(input int k);
    return (k / N == 1) ? ~P : P;
  endfunction

  // March C-style sequence on a plain array: w0; r0w1 up; r1w0 down; r0 down.
  function automatic void ref_run(output int first, output logic [7:0] fa, output logic [7:0] fd);
    logic [7:0] m [N];
    first = -1; fa = '0; fd = '0;
    for (int a = 0; a < N; a++) m[a] = 8'hxx;
    for (int k = 0; k < 4 * N; k++) begin
      int el = k / N;
      int a = ref_addr(k);
      bit we = (el < 3);
      logic [7:0] din = ref_din(k);
      logic [7:0] exp = (el == 2) ? ~P : P;
      logic [7:0] r = (wf && we) ? din : m[a];
      r = (r & ~sa0[a]) | sa1[a];
      if (we) m[a] = din;
      if (el > 0 && r !== exp && first < 0) begin
        first = k; fa = 8'(a); fd = r;
      end
    end
  endfunction

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin sa0[a] = '0; sa1[a] = '0; end
    wf = 1'b0;
  endtask

  task automatic do_run(input int pulse_k);
    int first;
    logic [7:0] fa, fd;
    ref_run(first, fa, fd);
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 4 * N + 1; k++) begin
      start = (k == pulse_k);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("we", sram_we, 32'(k < 3 * N));
      if (k < 4 * N) begin
        chk("addr", sram_addr, ref_addr(k));
        chk("din", sram_din, ref_din(k));
      end
      chk("fail_timing", fail, 32'(first >= 0 && k >= first + 2));
      @(negedge clk);
    end
    start = 1'b0;
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_fail", fail, 32'(first >= 0));
    chk("end_fail_addr", fail_addr, fa);
    chk("end_fail_data", fail_data, fd);
    @(negedge clk);
    chk("done_hold", done, 1);
  endtask

  initial begin
    for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
    clear_faults();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_data", fail_data, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_din", sram_din, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fault-free run.
    do_run(-1);

    // Single stuck-at-1 on bit 0 of address 5.
    sa1[5] = 8'h01;
    do_run(-1);
    chk("sa1_5_addr", fail_addr, 5);
    chk("sa1_5_data", fail_data, 8'hAB);

    // Two faults; address 12 is met first in the descending element.
    clear_faults();
    sa0[3]  = 8'h80;
    sa1[12] = 8'h01;
    do_run(20);
    chk("two_fault_addr", fail_addr, 12);
    chk("two_fault_data", fail_data, 8'hAB);

    // Restart from DONE clears fail; start pulses while busy are ignored.
    clear_faults();
    do_run(33);

    // Asynchronous reset mid-run, with an early write-first failure in flight.
    wf = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_fail", fail, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fail", fail, 0);
    chk("mid_rst_fail_addr", fail_addr, 0);
    chk("mid_rst_fail_data", fail_data, 0);
    chk("mid_rst_we", sram_we, 0);
    chk("mid_rst_addr", sram_addr, 0);
    chk("mid_rst_din", sram_din, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_we", sram_we, 0);
    end
    clear_faults();
    do_run(-1);

    // Write-first memory breaks the merged read/write at M1 address 0.
    wf = 1'b1;
    do_run(-1);
    chk("wf_addr", fail_addr, 0);
    chk("wf_data", fail_data, 8'hAA);

    // Randomized fault sets, start pulses and idle gaps.
    for (int r = 0; r < 6; r++) begin
      clear_faults();
      for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
        int a = $urandom_range(0, N - 1);
        int b = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) sa1[a][b] = 1'b1;
        else                           sa0[a][b] = 1'b1;
      end
      wf = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4 * N)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
